// File: rtl/seq_detect_ctrl_if.sv
// Host/config and symbol-stream signal bundle for the programmable sequence detector.
interface seq_detect_ctrl_if #(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = AW + 1;

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [SYM_W-1:0] cfg_sym;
  logic             cfg_len_we;
  logic [LW-1:0]    cfg_len;
  logic             oneshot;
  logic             arm;
  logic             disarm;
  logic             data_valid;
  logic [SYM_W-1:0] data;

  logic             armed;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             timeout;
  logic             cfg_err;
  logic [LW-1:0]    pos;

  modport master (
    output cfg_we, cfg_addr, cfg_sym, cfg_len_we, cfg_len, oneshot,
           arm, disarm, data_valid, data,
    input  armed, match, match_count, timeout, cfg_err, pos
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sym, cfg_len_we, cfg_len, oneshot,
           arm, disarm, data_valid, data,
    output armed, match, match_count, timeout, cfg_err, pos
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Runtime-programmable symbol pattern matcher: pattern RAM, arm/disarm control,
// match position walk, saturating match counter and inter-symbol timeout.
module seq_detect_ctrl #(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  seq_detect_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    MATCHING = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [LW-1:0]    pos_q, pos_n;
  logic [LW-1:0]    len_q, len_n;
  logic [IW-1:0]    idle_q, idle_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             match_q, match_n;
  logic             timeout_q, timeout_n;
  logic             err_q, err_n;
  logic             armed_q, armed_n;

  logic [SYM_W-1:0] pat [MAX_LEN];
  logic             pat_we_c;
  logic             complete_c;
  logic             pos_hit_c;
  logic             first_hit_c;
  logic             last_c;
  logic             len_ok_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Pattern storage; contents are meaningless until loaded, so no reset
  always_ff @(posedge clk) begin
    if (pat_we_c) begin
      pat[bus.cfg_addr] <= bus.cfg_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      len_q     <= '0;
      idle_q    <= '0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      pos_q     <= pos_n;
      len_q     <= len_n;
      idle_q    <= idle_n;
      cnt_q     <= cnt_n;
      match_q   <= match_n;
      timeout_q <= timeout_n;
      err_q     <= err_n;
      armed_q   <= armed_n;
    end
  end

  assign pos_hit_c   = (bus.data == pat[pos_q[AW-1:0]]);
  assign first_hit_c = (bus.data == pat[0]);
  assign last_c      = (pos_q == (len_q - LW'(1)));
  assign len_ok_c    = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));
  assign cnt_inc_c   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));

  // Next-state, config acceptance and output pulse generation
  always_comb begin
    state_n    = state_q;
    pos_n      = pos_q;
    len_n      = len_q;
    idle_n     = idle_q;
    cnt_n      = cnt_q;
    match_n    = 1'b0;
    timeout_n  = 1'b0;
    err_n      = 1'b0;
    pat_we_c   = 1'b0;
    complete_c = 1'b0;

    if (bus.cfg_we || bus.cfg_len_we) begin
      if (state_q != IDLE) begin
        err_n = 1'b1;
      end else begin
        pat_we_c = bus.cfg_we && !reset;
        if (bus.cfg_len_we) begin
          if (len_ok_c) begin
            len_n = bus.cfg_len;
          end else begin
            err_n = 1'b1;
          end
        end
      end
    end

    if (bus.disarm) begin
      state_n = IDLE;
      pos_n   = '0;
      idle_n  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.arm) begin
            if (len_q != '0) begin
              state_n = ARMED;
              cnt_n   = '0;
              pos_n   = '0;
              idle_n  = '0;
            end else begin
              err_n = 1'b1;
            end
          end
        end

        ARMED: begin
          if (bus.data_valid && first_hit_c) begin
            if (len_q == LW'(1)) begin
              complete_c = 1'b1;
            end else begin
              state_n = MATCHING;
              pos_n   = LW'(1);
              idle_n  = '0;
            end
          end
        end

        MATCHING: begin
          if (bus.data_valid) begin
            idle_n = '0;
            if (pos_hit_c) begin
              if (last_c) begin
                complete_c = 1'b1;
              end else begin
                pos_n = pos_q + LW'(1);
              end
            end else if (first_hit_c) begin
              if (len_q == LW'(1)) begin
                complete_c = 1'b1;
              end else begin
                pos_n = LW'(1);
              end
            end else begin
              state_n = ARMED;
              pos_n   = '0;
            end
          end else if (idle_q == IW'(TIMEOUT - 1)) begin
            state_n   = ARMED;
            pos_n     = '0;
            idle_n    = '0;
            timeout_n = 1'b1;
          end else begin
            idle_n = idle_q + IW'(1);
          end
        end

        default: begin
          state_n = IDLE;
          pos_n   = '0;
          idle_n  = '0;
        end
      endcase
    end

    // Matches never overlap: position restarts from the first symbol
    if (complete_c) begin
      match_n = 1'b1;
      cnt_n   = cnt_inc_c;
      pos_n   = '0;
      idle_n  = '0;
      state_n = bus.oneshot ? IDLE : ARMED;
    end
  end

  assign armed_n = (state_n != IDLE);

  assign bus.armed       = armed_q;
  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.timeout     = timeout_q;
  assign bus.cfg_err     = err_q;
  assign bus.pos         = pos_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: each driven cycle queues the expected
// registered outputs, a negedge monitor pops and compares them.
module tb_seq_detect_ctrl;

  localparam int unsigned SYM_W   = 3;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected word layout: {match, match_count[1:0], pos[3:0], armed, timeout, cfg_err}
  typedef struct {
    int         due;
    logic [9:0] exp;
    string      nm;
  } sb_t;

  sb_t        sb[$];
  sb_t        cur;
  logic [9:0] act;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      act = {bus.match, bus.match_count, bus.pos, bus.armed, bus.timeout, bus.cfg_err};
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s: got {m,cnt,pos,armed,to,err}=%b expected %b", cur.nm, act, cur.exp);
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] s, input logic em, input logic [1:0] ec,
                      input logic [3:0] ep, input logic ea, input logic et, input logic ee,
                      input string nm);
    sb_t t;
    bus.data_valid = v;
    bus.data       = s;
    t.due = cyc + 1;
    t.exp = {em, ec, ep, ea, et, ee};
    t.nm  = nm;
    sb.push_back(t);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.arm        = 1'b0;
    bus.disarm     = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_len_we = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic load_pattern(input logic [1:0] cnt);
    logic [2:0] p [4];
    p = '{3'd1, 3'd5, 3'd6, 3'd0};
    for (int i = 0; i < 4; i++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(i);
      bus.cfg_sym  = p[i];
      step(0, 0, 0, cnt, 0, 0, 0, 0, "load_sym");
    end
    bus.cfg_len    = 4'd4;
    bus.cfg_len_we = 1'b1;
    step(0, 0, 0, cnt, 0, 0, 0, 0, "load_len");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.armed !== 1'b0)   begin errors++; $display("FAIL rst_armed: got %b expected 0", bus.armed); end
    checks++; if (bus.match !== 1'b0)   begin errors++; $display("FAIL rst_match: got %b expected 0", bus.match); end
    checks++; if (bus.match_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.match_count); end
    checks++; if (bus.pos !== 4'd0)     begin errors++; $display("FAIL rst_pos: got %0d expected 0", bus.pos); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b expected 0", bus.cfg_err); end
  endtask

  task automatic test_cfg_idle();
    bus.cfg_len = 4'd0; bus.cfg_len_we = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, "len0_err");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, "arm_len0_err");
    step(0, 0, 0, 0, 0, 0, 0, 0, "err_one_cycle");
    bus.cfg_len = 4'd9; bus.cfg_len_we = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, "len9_err");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, "arm_after_len9");
  endtask

  task automatic test_basic();
    load_pattern(0);
    bus.oneshot = 1'b0;
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 0, "arm");
    step(1, 1, 0, 0, 1, 1, 0, 0, "basic_s0");
    step(1, 5, 0, 0, 2, 1, 0, 0, "basic_s1");
    step(1, 6, 0, 0, 3, 1, 0, 0, "basic_s2");
    step(1, 0, 1, 1, 0, 1, 0, 0, "basic_match");
    step(0, 0, 0, 1, 0, 1, 0, 0, "match_one_cycle");
  endtask

  task automatic test_restart();
    bus.disarm = 1'b1;
    step(0, 0, 0, 1, 0, 0, 0, 0, "disarm_keeps_count");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 0, "rearm_clears_count");
    step(1, 1, 0, 0, 1, 1, 0, 0, "rs_s0");
    step(1, 5, 0, 0, 2, 1, 0, 0, "rs_s1");
    step(1, 1, 0, 0, 1, 1, 0, 0, "restart_pos1");
    step(1, 5, 0, 0, 2, 1, 0, 0, "rs_s3");
    step(1, 6, 0, 0, 3, 1, 0, 0, "rs_s4");
    step(1, 0, 1, 1, 0, 1, 0, 0, "restart_match");
  endtask

  task automatic test_timeout();
    step(1, 1, 0, 1, 1, 1, 0, 0, "to_s0");
    step(1, 5, 0, 1, 2, 1, 0, 0, "to_s1");
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      step(0, 0, 0, 1, 2, 1, 0, 0, "to_waiting");
    end
    step(0, 0, 0, 1, 0, 1, 1, 0, "timeout_pulse");
    step(1, 6, 0, 1, 0, 1, 0, 0, "after_to_s2");
    step(1, 0, 0, 1, 0, 1, 0, 0, "no_match_after_to");
  endtask

  task automatic test_reject_armed();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_sym = 3'd7;
    step(0, 0, 0, 1, 0, 1, 0, 1, "cfg_we_armed");
    bus.cfg_len = 4'd2; bus.cfg_len_we = 1'b1;
    step(0, 0, 0, 1, 0, 1, 0, 1, "cfg_len_armed");
    bus.arm = 1'b1;
    step(0, 0, 0, 1, 0, 1, 0, 0, "arm_ignored");
    step(1, 1, 0, 1, 1, 1, 0, 0, "kept_s0");
    step(1, 5, 0, 1, 2, 1, 0, 0, "kept_s1");
    step(1, 6, 0, 1, 3, 1, 0, 0, "kept_s2");
    step(1, 0, 1, 2, 0, 1, 0, 0, "pattern_kept");
  endtask

  task automatic test_saturation();
    logic [1:0] c;
    c = 2'd2;
    for (int r = 0; r < 3; r++) begin
      step(1, 1, 0, c, 1, 1, 0, 0, "sat_s0");
      step(1, 5, 0, c, 2, 1, 0, 0, "sat_s1");
      step(1, 6, 0, c, 3, 1, 0, 0, "sat_s2");
      if (c != 2'd3) c = c + 2'd1;
      step(1, 0, 1, c, 0, 1, 0, 0, "sat_match");
    end
  endtask

  task automatic test_oneshot();
    bus.oneshot = 1'b1;
    step(1, 1, 0, 3, 1, 1, 0, 0, "os_s0");
    step(1, 5, 0, 3, 2, 1, 0, 0, "os_s1");
    step(1, 6, 0, 3, 3, 1, 0, 0, "os_s2");
    step(1, 0, 1, 3, 0, 0, 0, 0, "oneshot_idle");
    step(1, 1, 0, 3, 0, 0, 0, 0, "idle_ignores_data");
    bus.oneshot = 1'b0;
  endtask

  task automatic test_len_bounds();
    bus.cfg_len = 4'd1; bus.cfg_len_we = 1'b1;
    step(0, 0, 0, 3, 0, 0, 0, 0, "len1_ok");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 0, "len1_arm");
    step(1, 3, 0, 0, 0, 1, 0, 0, "len1_miss");
    step(1, 1, 1, 1, 0, 1, 0, 0, "len1_match");
    step(1, 1, 1, 2, 0, 1, 0, 0, "len1_match2");
    step(1, 0, 0, 2, 0, 1, 0, 0, "len1_quiet");
    bus.disarm = 1'b1;
    step(0, 0, 0, 2, 0, 0, 0, 0, "len1_disarm");
    bus.cfg_len = 4'd8; bus.cfg_len_we = 1'b1;
    step(0, 0, 0, 2, 0, 0, 0, 0, "len8_ok");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 0, "len8_arm");
    bus.disarm = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, "len8_disarm");
    bus.cfg_len = 4'd4; bus.cfg_len_we = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, "len4_restore");
  endtask

  task automatic test_priority();
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 0, "pr_arm");
    step(1, 1, 0, 0, 1, 1, 0, 0, "pr_s0");
    step(1, 5, 0, 0, 2, 1, 0, 0, "pr_s1");
    step(1, 6, 0, 0, 3, 1, 0, 0, "pr_s2");
    bus.disarm = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, "disarm_suppress");
    step(0, 0, 0, 0, 0, 0, 0, 0, "disarm_no_late_match");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 0, "pr_rearm");
    step(1, 1, 0, 0, 1, 1, 0, 0, "rst_s0");
    step(1, 5, 0, 0, 2, 1, 0, 0, "rst_s1");
    reset = 1'b1;
    step(1, 6, 0, 0, 0, 0, 0, 0, "reset_mid");
    bus.arm = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, "arm_after_reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, "final_idle");
  endtask

  initial begin
    reset          = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_sym    = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    bus.oneshot    = 1'b0;
    bus.arm        = 1'b0;
    bus.disarm     = 1'b0;
    bus.data_valid = 1'b0;
    bus.data       = '0;
    @(posedge clk);
    #1;

    test_reset();
    test_cfg_idle();
    test_basic();
    test_restart();
    test_timeout();
    test_reject_armed();
    test_saturation();
    test_oneshot();
    test_len_bounds();
    test_priority();

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable controller for the 3-bit symbol-stream pattern matcher.
- Holds a pattern register file of up to MAX_LEN symbols, loaded through a config port.
- Arms and disarms matching, walks the match position, and counts completed matches.
- Flags inter-symbol timeouts.
- Sits between the host/config logic and the symbol stream; replaces a hard-coded detector FSM with a runtime-configurable one.

Parameters:
SYM_W, 3, symbol width in bits
MAX_LEN, 8, maximum pattern length in symbols (power of 2)
CNT_W, 8, match counter width
TIMEOUT, 16, idle cycles allowed between symbols while MATCHING (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  write pattern symbol
cfg_addr  in  log2(MAX_LEN)  symbol index for write
cfg_sym  in  SYM_W  symbol value
cfg_len_we  in  1  write pattern length
cfg_len  in  log2(MAX_LEN)+1  pattern length, 1..MAX_LEN
oneshot  in  1  1 = return to IDLE after first match; 0 = rearm
arm  in  1  start matching (pulse)
disarm  in  1  abort and return to IDLE (pulse)
data_valid  in  1  data carries a symbol this cycle
data  in  SYM_W  input symbol
armed  out  1  high in ARMED or MATCHING
match  out  1  one-cycle pulse, pattern completed
match_count  out  CNT_W  saturating count of matches since last arm
timeout  out  1  one-cycle pulse, inter-symbol timeout
cfg_err  out  1  one-cycle pulse, rejected config write or arm
pos  out  log2(MAX_LEN)+1  current match position (debug)

Behaviour:
Reset values:
- state=IDLE; armed, match, timeout, cfg_err = 0; match_count=0; pos=0; pattern length=0.
- Pattern RAM contents are don't-care after reset.

States: IDLE, ARMED, MATCHING.

Config:
- cfg_we and cfg_len_we are accepted only in IDLE.
- Any config write in ARMED or MATCHING is dropped, and cfg_err pulses the next cycle.
- A cfg_len outside 1..MAX_LEN is dropped and cfg_err pulses.

IDLE:
- arm with length>=1: go to ARMED, clear match_count, set pos=0.
- arm with length==0: stay in IDLE, cfg_err pulses.

ARMED:
- data_valid && data==pat[0]: if len==1 it is a match; otherwise go to MATCHING, pos=1.
- Any other symbol: stay in ARMED.

MATCHING:
- data_valid && data==pat[pos] && pos==len-1: match.
- data_valid && data==pat[pos] && pos<len-1: pos+1.
- data_valid && mismatch: restart. If data==pat[0], pos=1 and stay in MATCHING (or match if len==1); else pos=0 and go to ARMED. No other overlap handling.
- data_valid low: the idle counter increments. It is cleared on every valid symbol and on every state entry.
- Idle counter reaching TIMEOUT: go to ARMED, pos=0, timeout pulses the next cycle.

On match:
- match is registered and asserts the cycle after the completing symbol, for exactly 1 cycle.
- match_count increments and saturates at 2^CNT_W-1.
- Matches do not overlap: pos returns to 0.
- oneshot=1: next state is IDLE. oneshot=0: next state is ARMED.

Priority and simultaneous events:
- reset > disarm > arm > data.
- disarm in any state: go to IDLE next cycle, pos=0, and suppress any match or timeout that would have occurred that cycle. match_count is retained.
- arm while already armed: ignored, with no cfg_err.
- A completing symbol in the same cycle as a timeout expiry cannot occur, because the counter is cleared by data_valid.

Latency and outputs:
- Symbol-to-match latency is 1 cycle.
- armed and pos reflect registered state.

Reset mid-operation: returns every output to its reset value on the next edge. The pattern length is also cleared, so the pattern must be reloaded.

Test Plan:
- Basic match: load pattern 001,101,110,000 (len=4), oneshot=0, arm, stream 001,101,110,000 -> match high exactly 1 cycle after the 000 symbol; match_count=1; back in ARMED with pos=0.
- Restart on first symbol: stream 001,101,001,101,110,000 -> no match at the third symbol; pos goes to 1 at the second 001; single match at the end; match_count=1.
- Timeout: TIMEOUT=16, send 001,101 then hold data_valid=0 for 16 cycles -> timeout pulse, pos=0, armed=1. Send 110,000 afterward -> no match.
- Oneshot and saturation: with oneshot=1, one match -> state IDLE, armed=0. With CNT_W=2, oneshot=0 and 5 matches -> match_count stays 3.
- Rejected config: cfg_we while armed -> cfg_err pulse, pattern unchanged. cfg_len=0 then arm -> cfg_err, armed stays 0.
- Priority: disarm asserted in the same cycle as the completing symbol -> no match pulse, IDLE next cycle. Sync reset mid-MATCHING -> every output at its reset value next cycle.
